// File: rtl/compress_seq.sv
// compress_seq: linear 14-bit sample to G.711 u-law/A-law code by sequential segment search; ports test_clk, reset_n (sync, active low), sin/law/in_valid/in_ready in, sout/out_valid/out_ready out, clip only with COMPRESS_CLIP_FLAG_EN
module compress_seq (
  input  logic        test_clk,
  input  logic        reset_n,
  input  logic [13:0] sin,
  input  logic        law,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  sout,
  output logic        out_valid,
  input  logic        out_ready
`ifdef COMPRESS_CLIP_FLAG_EN
  ,output logic       clip
`endif
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_nx;
  logic neg, alaw, busy;
  logic [12:0] w, mag, w_load;
  logic [13:0] sum;
  logic [2:0] k, e;
  logic [7:0] code;
  always_comb begin
    mag = sin[13] ? ~sin[12:0] : sin[12:0];
    sum = {1'b0, mag} + 14'd33;
    w_load = law ? {2'b00, mag[12:2]} : (sum[13] ? 13'h1fff : sum[12:0]);
    busy = alaw ? (w >= 13'd32) : (w >= 13'd64);
    e = k + {2'b00, w >= 13'd16};
    code = alaw ? ({~neg, e, w[3:0]} ^ 8'h55) : {~neg, 3'd7 - k, ~w[4:1]};
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = state == IDLE ? (in_valid ? SEARCH : IDLE) :
               state == SEARCH ? (busy ? SEARCH : DONE) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge test_clk) begin
    if (!reset_n) begin
      state <= IDLE;
      sout <= 8'h00;
`ifdef COMPRESS_CLIP_FLAG_EN
      clip <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        neg <= sin[13];
        alaw <= law;
        w <= w_load;
        k <= 3'd0;
`ifdef COMPRESS_CLIP_FLAG_EN
        clip <= !law && sum[13];
`endif
      end else if (state == SEARCH) begin
        if (busy) begin
          w <= w >> 1;
          k <= k + 3'd1;
        end else sout <= code;
      end
    end
  end
endmodule

// File: tb/tb_compress_seq.sv
// tb_compress_seq: scoreboard bench comparing compress_seq against a table-driven G.711 encoder model
module tb_compress_seq;
  logic test_clk = 0, reset_n = 0, law = 0, in_valid = 0, out_ready = 0;
  logic [13:0] sin = 0;
  logic in_ready, out_valid;
  logic [7:0] sout;
  logic clip_w;
  int total = 0, bad = 0;
  typedef struct packed {logic [7:0] code; logic clip; logic [3:0] lat;} exp_t;
  exp_t q[$];

  compress_seq dut (
    .test_clk(test_clk), .reset_n(reset_n), .sin(sin), .law(law), .in_valid(in_valid),
    .in_ready(in_ready), .sout(sout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef COMPRESS_CLIP_FLAG_EN
    ,.clip(clip_w)
`endif
  );
`ifndef COMPRESS_CLIP_FLAG_EN
  assign clip_w = 1'b0;
`endif

  always #5 test_clk = ~test_clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Classic segment-table encoders working on the one's-complement magnitude.
  function automatic exp_t model(input logic l, input logic [13:0] s);
    int v, m, seg, k;
    exp_t r;
    v = int'($signed(s));
    m = v < 0 ? -v - 1 : v;
    seg = 8;
    if (!l) begin
      r.clip = (m + 33) > 8191;
      m = (m + 33) > 8191 ? 8191 : m + 33;
      for (int i = 0; i < 8; i++) if (seg == 8 && m < (64 << i)) seg = i;
      r.code = 8'(((seg << 4) | ((m >> (seg + 1)) & 15)) ^ (v < 0 ? 8'h7F : 8'hFF));
      k = seg;
    end else begin
      r.clip = 1'b0;
      m = m >> 1;
      for (int i = 0; i < 8; i++) if (seg == 8 && m < (32 << i)) seg = i;
      r.code = 8'(((seg << 4) | (seg < 2 ? (m >> 1) & 15 : (m >> seg) & 15)) ^ (v < 0 ? 8'h55 : 8'hD5));
      k = seg < 2 ? 0 : seg - 1;
    end
    r.lat = 4'(k + 1);
    return r;
  endfunction

  task automatic run(input logic l, input logic [13:0] s, input int hold);
    int n;
    exp_t e;
    logic [7:0] held;
    @(negedge test_clk);
    law = l; sin = s; in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge test_clk); n++; end
    if (!in_ready) begin chk("accept", 0, 1); in_valid = 0; return; end
    @(posedge test_clk);
    q.push_back(model(l, s));
    #1;
    if (hold == 0) in_valid = 0; else begin sin = ~s; law = ~l; end
    n = 0;
    do begin @(posedge test_clk); n++; @(negedge test_clk); end while (!out_valid && n < 12);
    e = q.pop_front();
    chk("out_valid", int'(out_valid), 1);
    chk("sout", int'(sout), int'(e.code));
    chk("latency", n, int'(e.lat));
`ifdef COMPRESS_CLIP_FLAG_EN
    chk("clip", int'(clip_w), int'(e.clip));
`endif
    held = sout;
    for (int i = 0; i < hold; i++) begin
      @(posedge test_clk); @(negedge test_clk);
      chk("hold_sout", int'(sout), int'(held));
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
    end
    out_ready = 1; in_valid = 0;
    @(posedge test_clk); @(negedge test_clk);
    out_ready = 0;
    chk("back_idle", int'(in_ready), 1);
    chk("out_valid_drop", int'(out_valid), 0);
  endtask

  initial begin
    int m, seen;
    repeat (3) @(posedge test_clk);
    @(negedge test_clk);
    reset_n = 1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sout", int'(sout), 0);
    chk("rst_clip", int'(clip_w), 0);
    run(0, 14'h0000, 0);
    run(0, 14'h1FFF, 0);
    run(0, 14'h3FFF, 0);
    run(1, 14'h0000, 0);
    run(1, 14'h2000, 0);
    run(1, 14'h0040, 0);
    run(0, 14'h0123, 5);
    run(1, 14'h3456, 5);
    for (int b = 2; b < 14; b++)
      for (int d = -1; d <= 0; d++)
        for (int l = 0; l < 2; l++) begin
          m = (1 << b) + d;
          if (m > 8191) m = 8191;
          run(l[0], 14'(m), 0);
          run(l[0], ~14'(m), 0);
        end
    for (int i = 0; i < 8; i++)
      for (int d = -34; d <= -33; d++) begin
        m = (64 << i) + d;
        run(0, 14'(m), 0);
        run(0, ~14'(m), 0);
      end
    for (int i = 0; i < 1200; i++) run(i[0], 14'($urandom), i % 97 == 0 ? 2 : 0);
    run(0, 14'h0000, 0);
    @(negedge test_clk);
    law = 0; sin = 14'h1FFF; in_valid = 1;
    @(posedge test_clk);
    #1 in_valid = 0;
    @(posedge test_clk); @(posedge test_clk);
    @(negedge test_clk);
    reset_n = 0;
    @(posedge test_clk);
    @(negedge test_clk);
    reset_n = 1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_sout", int'(sout), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_clip", int'(clip_w), 0);
    seen = 0;
    repeat (12) begin @(posedge test_clk); @(negedge test_clk); if (out_valid) seen++; end
    chk("mid_rst_no_pulse", seen, 0);
    run(1, 14'h0040, 0);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/compress_seq.md
COMPRESS_SEQ -- requirements
Module: compress_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 CLK  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 RESET_N  input  1  synchronous, active-low reset.
REQ-004 SIN  input  14  linear sample, two's complement; this is the format the EXPAND block produces.
REQ-005 LAW  input  1  1 = A-law, 0 = u-law; sampled only on acceptance.
REQ-006 IN_VALID  input  1  SIN and LAW are valid.
REQ-007 IN_READY  output  1  block can accept a sample.
REQ-008 SOUT  output  8  log-PCM code (G.711).
REQ-009 OUT_VALID  output  1  SOUT is valid.
REQ-010 OUT_READY  input  1  consumer takes SOUT.
REQ-011 CLIP  output  1  u-law magnitude saturated; the port exists only when COMPRESS_CLIP_FLAG_EN is defined.

Function
REQ-012 The FSM SHALL have three states: IDLE, SEARCH and DONE. IN_READY = (state==IDLE). OUT_VALID = (state==DONE).
REQ-013 Acceptance SHALL occur at a rising edge where IN_VALID & IN_READY. On acceptance the block SHALL:
- register the sign neg = SIN[13] and the LAW value;
- register the working value W, clear the shift counter K (3 bits), and go to SEARCH.
REQ-014 The working value W SHALL be loaded as follows:
- u-law: W = (neg ? ~SIN : SIN) + 33, zero-extended and saturated to 8191.
- A-law: W = (neg ? ~SIN : SIN) >> 2, giving a range of 0..2047.
REQ-015 In SEARCH, while (u-law: W >= 64) or (A-law: W >= 32), each cycle SHALL do W <= W >> 1 and K <= K+1.
REQ-016 In SEARCH, when the REQ-015 condition is false, the block SHALL register SOUT and go to DONE in that same cycle.
REQ-017 u-law result: SOUT = {~neg, 3'(7-K), ~W[4:1]}.
REQ-018 A-law result: E = K + (W >= 16), M = W[3:0], SOUT = {~neg, E[2:0], M} XOR 8'h55.
REQ-019 Latency SHALL be K+1 cycles from the acceptance edge to OUT_VALID high. This is at least 1 cycle, at most 8 for u-law and at most 7 for A-law.
REQ-020 In DONE:
- SOUT and OUT_VALID (and CLIP) SHALL hold stable until a rising edge with OUT_READY=1.
- That edge SHALL return the FSM to IDLE.
- No sample SHALL be accepted in the same edge.
REQ-021 SIN, LAW and IN_VALID SHALL be ignored outside IDLE. OUT_READY SHALL be ignored outside DONE.

Reset
REQ-022 At a rising edge with RESET_N=0, the block SHALL enter IDLE and set SOUT=8'h00, OUT_VALID=0 and CLIP=0. IN_READY SHALL be 1 at the first edge after RESET_N returns high.
REQ-023 Reset SHALL win over every simultaneous event. A sample in SEARCH or DONE SHALL be discarded with no OUT_VALID pulse.

Configuration
REQ-024 With COMPRESS_CLIP_FLAG_EN defined:
- CLIP SHALL be registered on acceptance and held with the result.
- CLIP = 1 if the u-law pre-saturation sum exceeds 8191.
- CLIP SHALL always be 0 for A-law.
REQ-025 Without COMPRESS_CLIP_FLAG_EN, the CLIP port and its logic SHALL be absent. Saturation SHALL be unchanged.

Verification
REQ-026 LAW=0, SIN=14'h0000 -> SOUT=8'hFF, OUT_VALID 1 cycle after acceptance, CLIP=0.
REQ-027 LAW=0, SIN=14'h1FFF -> SOUT=8'h80 after 8 cycles, CLIP=1 (if enabled). LAW=0, SIN=14'h3FFF -> SOUT=8'h7F.
REQ-028 LAW=1, SIN=14'h0000 -> SOUT=8'hD5, latency 1. LAW=1, SIN=14'h2000 -> SOUT=8'h2A, latency 7. LAW=1, SIN=14'h0040 -> SOUT=8'hC5.
REQ-029 Hold OUT_READY=0 for 5 cycles in DONE with IN_VALID=1 -> SOUT stable, IN_READY=0, no second acceptance, IDLE one cycle after OUT_READY=1.
REQ-030 RESET_N=0 for one edge during SEARCH of SIN=14'h1FFF -> OUT_VALID never rises for that sample, SOUT=8'h00, IN_READY=1 on the next edge.
REQ-031 Full sweep of all 16384 SIN values for both LAW settings -> SOUT matches the G.711 compress reference model. The EXPAND block applied to SOUT returns the quantized value.
